// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: follows destination register and Tnew through E/M/W,
// producing the stall request, forwarding selects and a saturating stall counter.
module hazard_tracker #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       d_a3,
   input  logic             d_regwrite,
   input  logic [1:0]       d_tnew,
   input  logic [4:0]       d_rs,
   input  logic [4:0]       d_rt,
   input  logic [1:0]       d_tuse_rs,
   input  logic [1:0]       d_tuse_rt,
   output logic             stall,
   output logic [1:0]       fwd_d_rs,
   output logic [1:0]       fwd_d_rt,
   output logic [1:0]       fwd_e_rs,
   output logic [1:0]       fwd_e_rt,
   output logic             fwd_m_rt,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [4:0] e_a3, e_rs, e_rt, m_a3, m_rt, w_a3;
   logic [1:0] e_tnew, m_tnew;
   logic [1:0] d_tnew_clip;
   logic       stall_rs, stall_rt;

   assign d_tnew_clip = (d_tnew == 2'd3) ? 2'd2 : d_tnew;

   // An operand stalls only when its producer's result arrives later than it is consumed.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (d_rs != '0 && d_tuse_rs != 2'd3)
         stall_rs = (d_rs == e_a3 && e_tnew > d_tuse_rs) ||
                    (d_rs == m_a3 && m_tnew > d_tuse_rs);
      if (d_rt != '0 && d_tuse_rt != 2'd3)
         stall_rt = (d_rt == e_a3 && e_tnew > d_tuse_rt) ||
                    (d_rt == m_a3 && m_tnew > d_tuse_rt);
      stall = stall_rs | stall_rt;
   end

   always_comb begin
      fwd_d_rs = 2'd0;
      if (d_rs != '0 && d_rs == e_a3 && e_tnew == 2'd0)      fwd_d_rs = 2'd1;
      else if (d_rs != '0 && d_rs == m_a3 && m_tnew == 2'd0) fwd_d_rs = 2'd2;

      fwd_d_rt = 2'd0;
      if (d_rt != '0 && d_rt == e_a3 && e_tnew == 2'd0)      fwd_d_rt = 2'd1;
      else if (d_rt != '0 && d_rt == m_a3 && m_tnew == 2'd0) fwd_d_rt = 2'd2;

      fwd_e_rs = 2'd0;
      if (e_rs != '0 && e_rs == m_a3 && m_tnew == 2'd0) fwd_e_rs = 2'd1;
      else if (e_rs != '0 && e_rs == w_a3)              fwd_e_rs = 2'd2;

      fwd_e_rt = 2'd0;
      if (e_rt != '0 && e_rt == m_a3 && m_tnew == 2'd0) fwd_e_rt = 2'd1;
      else if (e_rt != '0 && e_rt == w_a3)              fwd_e_rt = 2'd2;

      fwd_m_rt = (m_rt != '0) && (m_rt == w_a3);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_a3      <= '0;
         e_tnew    <= '0;
         e_rs      <= '0;
         e_rt      <= '0;
         m_a3      <= '0;
         m_tnew    <= '0;
         m_rt      <= '0;
         w_a3      <= '0;
         stall_cnt <= '0;
      end else begin
         if (stall) begin
            e_a3   <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
         end else begin
            e_a3   <= d_regwrite ? d_a3 : 5'd0;
            e_tnew <= d_tnew_clip;
            e_rs   <= d_rs;
            e_rt   <= d_rt;
         end
         m_a3   <= e_a3;
         m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
         m_rt   <= e_rt;
         w_a3   <= m_a3;
      end
   end

endmodule
